jk_bank_driver: RTL and testbench

JK_BANK_DRIVER -- requirements
Module: jk_bank_driver

---
 rtl/jk_bank_driver.sv | 126 ++++++++++++
 tb/tb_jk_bank_driver.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/jk_bank_driver.sv
// jk_bank_driver: drives a bank of WIDTH JK flip-flops toward a target word.
// After driving, it checks the q feedback. On a mismatch it re-drives up to
// MAX_RETRY times, and if the bank still does not match it enters ERROR.
// Optional macro JK_TOGGLE_EN: when it is defined, excitation uses the toggle
// form (j = k = target ^ q). By default it uses the set/reset form.
module jk_bank_driver #(
    parameter int WIDTH     = 4,
    parameter int MAX_RETRY = 3
) (
    input  logic             clk,
    input  logic             clear_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] target,
    input  logic [WIDTH-1:0] q_fb,
    output logic [WIDTH-1:0] j,
    output logic [WIDTH-1:0] k,
    output logic             busy,
    output logic             done,
    output logic             err,
    input  logic             err_clr
);

    // Retry counter just wide enough to hold MAX_RETRY; it stops there, never wraps
    localparam int CNT_W = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);
    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_RETRY);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        DRIVE = 3'd1,
        CHECK = 3'd2,
        DONE  = 3'd3,
        ERROR = 3'd4
    } state_t;

    state_t             state_reg;
    logic [WIDTH-1:0]   target_reg;
    logic [CNT_W-1:0]   retry_cnt_reg;
    logic               done_reg;
    logic               err_reg;
    logic               busy_reg;
    logic               ready_reg;
    logic               drive_en;

    // Excitation is only live in DRIVE; the async reset of state_reg zeroes it at once
    assign drive_en = (state_reg == DRIVE);

    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_exc
`ifdef JK_TOGGLE_EN
            assign j[gi] = drive_en & (target_reg[gi] ^ q_fb[gi]);
            assign k[gi] = drive_en & (target_reg[gi] ^ q_fb[gi]);
`else
            assign j[gi] = drive_en &  target_reg[gi] & ~q_fb[gi];
            assign k[gi] = drive_en & ~target_reg[gi] &  q_fb[gi];
`endif
        end
    endgenerate

    assign in_ready = ready_reg;
    assign busy     = busy_reg;
    assign done     = done_reg;
    assign err      = err_reg;

    // Control FSM; status outputs are registered together with the next state
    always_ff @(posedge clk or negedge clear_n) begin
        if (!clear_n) begin
            state_reg     <= IDLE;
            target_reg    <= '0;
            retry_cnt_reg <= '0;
            done_reg      <= 1'b0;
            err_reg       <= 1'b0;
            busy_reg      <= 1'b0;
            ready_reg     <= 1'b1;
        end else begin
            done_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (in_valid && ready_reg) begin
                        target_reg    <= target;
                        retry_cnt_reg <= '0;
                        state_reg     <= DRIVE;
                        busy_reg      <= 1'b1;
                        ready_reg     <= 1'b0;
                    end
                end
                DRIVE: begin
                    state_reg <= CHECK;
                end
                CHECK: begin
                    if (q_fb == target_reg) begin
                        state_reg <= DONE;
                        done_reg  <= 1'b1;
                    end else if (retry_cnt_reg < MAX_CNT) begin
                        retry_cnt_reg <= retry_cnt_reg + 1'b1;
                        state_reg     <= DRIVE;
                    end else begin
                        state_reg <= ERROR;
                        err_reg   <= 1'b1;
                        busy_reg  <= 1'b0;
                    end
                end
                DONE: begin
                    // Returning through IDLE rules out a back-to-back accept
                    state_reg <= IDLE;
                    busy_reg  <= 1'b0;
                    ready_reg <= 1'b1;
                end
                ERROR: begin
                    if (err_clr) begin
                        state_reg <= IDLE;
                        err_reg   <= 1'b0;
                        ready_reg <= 1'b1;
                    end
                end
                default: begin
                    state_reg <= IDLE;
                    busy_reg  <= 1'b0;
                    err_reg   <= 1'b0;
                    ready_reg <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_jk_bank_driver.sv
// Bench for jk_bank_driver (WIDTH=4, MAX_RETRY=3) with a JK bank model on q_fb.
module tb_jk_bank_driver;

    logic       clk = 1'b0;
    logic       clear_n;
    logic       in_valid;
    logic       in_ready;
    logic [3:0] target;
    logic [3:0] q_fb = 4'b0000;
    logic [3:0] j;
    logic [3:0] k;
    logic       busy;
    logic       done;
    logic       err;
    logic       err_clr;

    // Bank model controls: a preload, and a number of drive edges to ignore
    logic       load_en   = 1'b0;
    logic [3:0] load_val  = 4'b0000;
    int         load_skip = 0;
    int         skip      = 0;

    int checks = 0;
    int errors = 0;

    jk_bank_driver #(.WIDTH(4), .MAX_RETRY(3)) dut (
        .clk      (clk),
        .clear_n  (clear_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .target   (target),
        .q_fb     (q_fb),
        .j        (j),
        .k        (k),
        .busy     (busy),
        .done     (done),
        .err      (err),
        .err_clr  (err_clr)
    );

    always #5 clk = ~clk;

    // JK bank: q+ = j&~q | ~k&q; can be told to ignore some drive edges
    always @(posedge clk) begin
        if (load_en) begin
            q_fb <= load_val;
            skip <= load_skip;
        end else if ((j | k) != 4'b0000) begin
            if (skip > 0) skip <= skip - 1;
            else          q_fb <= (j & ~q_fb) | (~k & q_fb);
        end
    end

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    typedef struct {
        logic [3:0] q_init;
        logic [3:0] tgt;
        logic [3:0] ej;
        logic [3:0] ek;
        int         skip;
        int         drives;
        bit         eerr;
    } vec_t;

    vec_t vecs[6];

    task automatic run_op(input vec_t v, input int idx);
        @(negedge clk);
        load_en = 1'b1; load_val = v.q_init; load_skip = v.skip;
        @(negedge clk);
        load_en = 1'b0;
        chk($sformatf("v%0d idle ready", idx), {7'd0, in_ready}, 8'd1);
        in_valid = 1'b1; target = v.tgt; err_clr = !v.eerr;
        @(negedge clk);
        in_valid = 1'b0;
        for (int d = 0; d < v.drives; d++) begin
            chk($sformatf("v%0d drive%0d j", idx, d), {4'd0, j}, {4'd0, v.ej});
            chk($sformatf("v%0d drive%0d k", idx, d), {4'd0, k}, {4'd0, v.ek});
            chk($sformatf("v%0d drive%0d busy/ready", idx, d), {6'd0, busy, in_ready}, 8'b10);
            @(negedge clk);
            chk($sformatf("v%0d check%0d jk/done", idx, d), {j, k}, 8'd0);
            chk($sformatf("v%0d check%0d done", idx, d), {7'd0, done}, 8'd0);
            if (d < v.drives - 1) @(negedge clk);
        end
        @(negedge clk);
        if (v.eerr) begin
            chk($sformatf("v%0d err/ready/busy", idx), {5'd0, err, in_ready, busy}, 8'b100);
            @(negedge clk);
            chk($sformatf("v%0d err hold", idx), {7'd0, err}, 8'd1);
            err_clr = 1'b1;
            @(negedge clk);
            chk($sformatf("v%0d err cleared", idx), {6'd0, err, in_ready}, 8'b01);
        end else begin
            chk($sformatf("v%0d done pulse", idx), {6'd0, done, in_ready}, 8'b10);
            @(negedge clk);
            chk($sformatf("v%0d after done", idx), {5'd0, done, in_ready, busy}, 8'b010);
            chk($sformatf("v%0d bank q", idx), {4'd0, q_fb}, {4'd0, v.tgt});
        end
        err_clr = 1'b0;
    endtask

    initial begin
        clear_n = 1'b0; in_valid = 1'b0; target = 4'b0000; err_clr = 1'b0;

`ifdef JK_TOGGLE_EN
        vecs[0] = '{4'b0000, 4'b1010, 4'b1010, 4'b1010, 0,   1, 1'b0};
        vecs[1] = '{4'b1111, 4'b0110, 4'b1001, 4'b1001, 0,   1, 1'b0};
        vecs[2] = '{4'b0101, 4'b0101, 4'b0000, 4'b0000, 0,   1, 1'b0};
        vecs[3] = '{4'b0000, 4'b0001, 4'b0001, 4'b0001, 100, 4, 1'b1};
        vecs[4] = '{4'b0011, 4'b1100, 4'b1111, 4'b1111, 0,   1, 1'b0};
        vecs[5] = '{4'b0000, 4'b1001, 4'b1001, 4'b1001, 1,   2, 1'b0};
`else
        vecs[0] = '{4'b0000, 4'b1010, 4'b1010, 4'b0000, 0,   1, 1'b0};
        vecs[1] = '{4'b1111, 4'b0110, 4'b0000, 4'b1001, 0,   1, 1'b0};
        vecs[2] = '{4'b0101, 4'b0101, 4'b0000, 4'b0000, 0,   1, 1'b0};
        vecs[3] = '{4'b0000, 4'b0001, 4'b0001, 4'b0000, 100, 4, 1'b1};
        vecs[4] = '{4'b0011, 4'b1100, 4'b1100, 4'b0011, 0,   1, 1'b0};
        vecs[5] = '{4'b0000, 4'b1001, 4'b1001, 4'b0000, 1,   2, 1'b0};
`endif

        // Reset state
        repeat (2) @(negedge clk);
        chk("reset jk", {j, k}, 8'd0);
        chk("reset ready/busy/done/err", {4'd0, in_ready, busy, done, err}, 8'b1000);
        clear_n = 1'b1;

        for (int i = 0; i < 6; i++) run_op(vecs[i], i);

        // Reset asserted in the middle of DRIVE aborts the operation at once
        @(negedge clk);
        load_en = 1'b1; load_val = 4'b0000; load_skip = 0;
        @(negedge clk);
        load_en = 1'b0; in_valid = 1'b1; target = 4'b1100;
        @(negedge clk);
        in_valid = 1'b0;
`ifdef JK_TOGGLE_EN
        chk("rst drive jk", {j, k}, 8'b1100_1100);
`else
        chk("rst drive jk", {j, k}, 8'b1100_0000);
`endif
        #2 clear_n = 1'b0;
        #1;
        chk("rst async jk", {j, k}, 8'd0);
        chk("rst async ready/busy/done", {5'd0, in_ready, busy, done}, 8'b100);
        @(negedge clk);
        clear_n = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk($sformatf("post-rst c%0d ready/busy/done", c), {5'd0, in_ready, busy, done}, 8'b100);
        end

        // New target offered during CHECK is ignored; second accept right after DONE
        load_en = 1'b1; load_val = 4'b0000; load_skip = 0;
        @(negedge clk);
        load_en = 1'b0; in_valid = 1'b1; target = 4'b0011;
        @(negedge clk);
        target = 4'b1100;
        @(negedge clk);
        chk("bp check ready", {7'd0, in_ready}, 8'd0);
        @(negedge clk);
        chk("bp done/ready", {6'd0, done, in_ready}, 8'b10);
        @(negedge clk);
        chk("bp idle ready", {7'd0, in_ready}, 8'd1);
        chk("bp first q", {4'd0, q_fb}, 8'b0000_0011);
        @(negedge clk);
        in_valid = 1'b0;
`ifdef JK_TOGGLE_EN
        chk("bp second drive jk", {j, k}, 8'b1111_1111);
`else
        chk("bp second drive jk", {j, k}, 8'b1100_0011);
`endif
        repeat (2) @(negedge clk);
        chk("bp second done", {7'd0, done}, 8'd1);
        @(negedge clk);
        chk("bp second q", {4'd0, q_fb}, 8'b0000_1100);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
